// File: rtl/regfile_wb_arbiter_pkg.sv
// ============================================================================
// regfile_wb_arbiter_pkg : shared defaults and issue-select encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_wb_arbiter_pkg;

  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 4;

  typedef enum logic [1:0] {
    ISS_NONE = 2'd0,
    ISS_A    = 2'd1,
    ISS_B    = 2'd2
  } iss_sel_e;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_fill_queue.sv
// ============================================================================
// wb_fill_queue : circular load-return FIFO with per-entry live bits, kill port
//                 and per-register pending vector
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_fill_queue
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_i,
  input  logic                         enq_live_i,
  input  logic [REG_W-1:0]             enq_reg_i,
  input  logic [DATA_W-1:0]            enq_data_i,
  input  logic                         deq_i,
  input  logic                         kill_i,
  input  logic [REG_W-1:0]             kill_reg_i,
  output logic                         head_live_o,
  output logic [REG_W-1:0]             head_reg_o,
  output logic [DATA_W-1:0]            head_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [(2**REG_W)-1:0]        pending_o
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int NUM_REGS = 2**REG_W;

  logic [DEPTH-1:0]  live_q, live_d;
  logic [REG_W-1:0]  reg_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  // Slots outside the occupied range are always dead, so pending needs no occupancy mask.
  always_comb begin
    live_d = live_q;
    if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (reg_q[i] == kill_reg_i) live_d[i] = 1'b0;
      end
    end
    if (deq_i) live_d[head_q] = 1'b0;
    if (enq_i) live_d[tail_q] = enq_live_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      live_q <= live_d;
      if (enq_i) tail_q <= tail_q + 1'b1;
      if (deq_i) head_q <= head_q + 1'b1;
      case ({enq_i, deq_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq_i) begin
      reg_q[tail_q]  <= enq_reg_i;
      data_q[tail_q] <= enq_data_i;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (live_q[i] && (reg_q[i] == REG_W'(r))) pending_o[r] = 1'b1;
      end
    end
  end

  assign head_live_o = live_q[head_q];
  assign head_reg_o  = reg_q[head_q];
  assign head_data_o = data_q[head_q];
  assign count_o     = count_q;

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : merges WB-stage writes (A, priority) and queued
//                      load returns (B) onto the single register-file write port
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         a_we,
  input  logic [REG_W-1:0]             a_reg,
  input  logic [DATA_W-1:0]            a_data,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [REG_W-1:0]             b_reg,
  input  logic [DATA_W-1:0]            b_data,
  output logic                         WriteReg,
  output logic [REG_W-1:0]             DstReg,
  output logic [DATA_W-1:0]            DstData,
  output logic [(2**REG_W)-1:0]        pending,
  output logic [$clog2(DEPTH+1)-1:0]   q_count
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic              w_a_issue;
  logic              w_b_accept;
  logic              w_b_live;
  logic              w_deq;
  logic              w_head_live;
  logic [REG_W-1:0]  w_head_reg;
  logic [DATA_W-1:0] w_head_data;
  iss_sel_e          sel_d;

  logic              WriteReg_q;
  logic [REG_W-1:0]  DstReg_q, DstReg_d;
  logic [DATA_W-1:0] DstData_q, DstData_d;

  assign b_ready    = (q_count < CNT_W'(DEPTH));
  assign w_a_issue  = a_we && (a_reg != '0);
  assign w_b_accept = b_valid && b_ready;
  // A in the same cycle is younger, so a matching B arrives already superseded.
  assign w_b_live   = (b_reg != '0) && !(a_we && (a_reg == b_reg));
  assign w_deq      = !w_a_issue && (q_count != '0);

  wb_fill_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .enq_i       (w_b_accept),
    .enq_live_i  (w_b_live),
    .enq_reg_i   (b_reg),
    .enq_data_i  (b_data),
    .deq_i       (w_deq),
    .kill_i      (a_we),
    .kill_reg_i  (a_reg),
    .head_live_o (w_head_live),
    .head_reg_o  (w_head_reg),
    .head_data_o (w_head_data),
    .count_o     (q_count),
    .pending_o   (pending)
  );

  always_comb begin
    sel_d     = ISS_NONE;
    DstReg_d  = DstReg_q;
    DstData_d = DstData_q;
    if (w_a_issue) begin
      sel_d     = ISS_A;
      DstReg_d  = a_reg;
      DstData_d = a_data;
    end else if (w_deq && w_head_live) begin
      sel_d     = ISS_B;
      DstReg_d  = w_head_reg;
      DstData_d = w_head_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WriteReg_q <= 1'b0;
      DstReg_q   <= '0;
      DstData_q  <= '0;
    end else begin
      WriteReg_q <= (sel_d != ISS_NONE);
      DstReg_q   <= DstReg_d;
      DstData_q  <= DstData_d;
    end
  end

  assign WriteReg = WriteReg_q;
  assign DstReg   = DstReg_q;
  assign DstData  = DstData_q;

endmodule

`default_nettype wire
